// File: rtl/dpc_insn_pkg.sv
// Shared opcode map, sequencer states and unit-select encoding for the
// DekatronPC instruction sequencer.
package dpc_insn_pkg;
  localparam int INSN_WIDTH_DEF = 4;

  localparam int OP_NOP        = 0;
  localparam int OP_INC        = 1;
  localparam int OP_DEC        = 2;
  localparam int OP_APINC      = 3;
  localparam int OP_APDEC      = 4;
  localparam int OP_LOOP_OPEN  = 5;
  localparam int OP_LOOP_CLOSE = 6;
  localparam int OP_OUT        = 7;
  localparam int OP_IN         = 8;
  localparam int OP_HALT       = 15;

  // One-hot lanes of the execute-side initiator.
  localparam int UNIT_AP   = 0;
  localparam int UNIT_DATA = 1;
  localparam int UNIT_OUT  = 2;
  localparam int UNIT_IN   = 3;
  localparam int UNIT_W    = 4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH_ACK,
    ST_FETCH_DONE,
    ST_DECODE,
    ST_EXEC_ACK,
    ST_EXEC_DONE,
    ST_NEXT,
    ST_PAUSE,
    ST_ERROR
  } seq_state_e;
endpackage

// File: rtl/req_ready_master.sv
// Two-phase Request/Ready initiator: raise Request, wait for Ready low (ACK),
// then Ready high (DONE), with a per-phase timeout counter.
module req_ready_master #(
  parameter int W              = 1,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_WIDTH       = 13
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         start,
  input  logic [W-1:0] sel,
  input  logic         ready,
  output logic [W-1:0] req,
  output logic         ack,
  output logic         done,
  output logic         timeout
);
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  logic                busy;
  logic                acked;
  logic [TO_WIDTH-1:0] cnt;

  assign busy    = |req;
  // Ready high before the ACK phase is just the unit idling, not completion.
  assign ack     = busy && !acked && !ready;
  assign done    = busy &&  acked &&  ready;
  assign timeout = busy && !ack && !done && (cnt == TO_LAST);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      req   <= '0;
      acked <= 1'b0;
      cnt   <= '0;
    end else if (start) begin
      req   <= sel;
      acked <= 1'b0;
      cnt   <= '0;
    end else if (busy) begin
      if (done || timeout) begin
        req   <= '0;
        acked <= 1'b0;
        cnt   <= '0;
      end else if (ack) begin
        acked <= 1'b1;
        cnt   <= '0;
      end else begin
        cnt   <= cnt + TO_WIDTH'(1);
      end
    end
  end
endmodule

// File: rtl/insn_sequencer.sv
// Fetches opcodes from the IP line and dispatches them to the AP, data or
// console I/O unit over the Request/Ready handshake.
module insn_sequencer import dpc_insn_pkg::*; #(
  parameter int INSN_WIDTH     = dpc_insn_pkg::INSN_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_WIDTH       = 13
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Run,
  input  logic                  StepMode,
  input  logic                  Step,
  output logic                  IpRequest,
  input  logic                  IpReady,
  input  logic [INSN_WIDTH-1:0] IpInsn,
  output logic                  dataIsZeroed,
  output logic                  ApRequest,
  output logic                  ApDec,
  input  logic                  ApReady,
  output logic                  DataRequest,
  output logic                  DataDec,
  input  logic                  DataReady,
  input  logic                  DataZero,
  output logic                  IoOutRequest,
  output logic                  IoInRequest,
  input  logic                  IoReady,
  output logic [INSN_WIDTH-1:0] Insn,
  output logic                  Halted,
  output logic                  Error
);
  seq_state_e          state, state_nxt;
  logic                ip_start, ip_ack, ip_done, ip_to;
  logic                ex_start, ex_ack, ex_done, ex_to, ex_ready;
  logic [UNIT_W-1:0]   ex_sel, ex_req;
  logic [0:0]          ip_req;

  req_ready_master #(.W(1), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TO_WIDTH(TO_WIDTH)) u_ip (
    .Clk(Clk), .Rst(Rst), .start(ip_start), .sel(1'b1), .ready(IpReady),
    .req(ip_req), .ack(ip_ack), .done(ip_done), .timeout(ip_to)
  );

  req_ready_master #(.W(UNIT_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TO_WIDTH(TO_WIDTH)) u_ex (
    .Clk(Clk), .Rst(Rst), .start(ex_start), .sel(ex_sel), .ready(ex_ready),
    .req(ex_req), .ack(ex_ack), .done(ex_done), .timeout(ex_to)
  );

  assign IpRequest    = ip_req[0];
  assign ApRequest    = ex_req[UNIT_AP];
  assign DataRequest  = ex_req[UNIT_DATA];
  assign IoOutRequest = ex_req[UNIT_OUT];
  assign IoInRequest  = ex_req[UNIT_IN];
  assign ex_ready     = |(ex_req & {IoReady, IoReady, DataReady, ApReady});

  always_ff @(posedge Clk) begin
    if (Rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:       if (Run && !Halted && !Error) state_nxt = ST_FETCH_ACK;
      ST_FETCH_ACK:  if (ip_to) state_nxt = ST_ERROR; else if (ip_ack)  state_nxt = ST_FETCH_DONE;
      ST_FETCH_DONE: if (ip_to) state_nxt = ST_ERROR; else if (ip_done) state_nxt = ST_DECODE;
      ST_DECODE: begin
        case (int'(Insn))
          OP_INC, OP_DEC, OP_APINC, OP_APDEC, OP_OUT, OP_IN: state_nxt = ST_EXEC_ACK;
          OP_HALT: state_nxt = ST_IDLE;
          default: state_nxt = ST_NEXT;  // loops resolve in the IP line on the next fetch
        endcase
      end
      ST_EXEC_ACK:   if (ex_to) state_nxt = ST_ERROR; else if (ex_ack)  state_nxt = ST_EXEC_DONE;
      ST_EXEC_DONE:  if (ex_to) state_nxt = ST_ERROR; else if (ex_done) state_nxt = ST_NEXT;
      ST_NEXT: begin
        if (StepMode)  state_nxt = ST_PAUSE;
        else if (!Run) state_nxt = ST_IDLE;
        else           state_nxt = ST_FETCH_ACK;
      end
      ST_PAUSE:      if (Step) state_nxt = Run ? ST_FETCH_ACK : ST_IDLE;
      ST_ERROR:      state_nxt = ST_ERROR;
      default:       state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ex_sel = '0;
    case (int'(Insn))
      OP_INC, OP_DEC:     ex_sel[UNIT_DATA] = 1'b1;
      OP_APINC, OP_APDEC: ex_sel[UNIT_AP]   = 1'b1;
      OP_OUT:             ex_sel[UNIT_OUT]  = 1'b1;
      OP_IN:              ex_sel[UNIT_IN]   = 1'b1;
      default:            ex_sel            = '0;
    endcase
    ip_start = (state_nxt == ST_FETCH_ACK) && (state != ST_FETCH_ACK);
    ex_start = (state == ST_DECODE) && (state_nxt == ST_EXEC_ACK);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      dataIsZeroed <= 1'b0;
      Insn         <= '0;
      ApDec        <= 1'b0;
      DataDec      <= 1'b0;
      Halted       <= 1'b0;
      Error        <= 1'b0;
    end else begin
      // Captured with the rising IpRequest and frozen for the whole fetch.
      if (ip_start) dataIsZeroed <= DataZero;
      if (state == ST_FETCH_DONE && ip_done) Insn <= IpInsn;
      if (ex_start) begin
        if (ex_sel[UNIT_AP])   ApDec   <= (int'(Insn) == OP_APDEC);
        if (ex_sel[UNIT_DATA]) DataDec <= (int'(Insn) == OP_DEC);
      end
      if (state == ST_DECODE && int'(Insn) == OP_HALT) Halted <= 1'b1;
      if (ip_to || ex_to) Error <= 1'b1;
    end
  end
endmodule

// File: tb/tb_insn_sequencer.sv
// Self-checking bench: behavioural IP/execution units, program memory model
// and expected-transaction list derived from the opcode rules.
module tb_insn_sequencer;
  logic       Clk = 1'b0;
  logic       Rst, Run, StepMode, Step;
  logic       IpRequest, IpReady, dataIsZeroed;
  logic [3:0] IpInsn, Insn;
  logic       ApRequest, ApDec, ApReady, DataRequest, DataDec, DataReady, DataZero;
  logic       IoOutRequest, IoInRequest, IoReady, Halted, Error;

  insn_sequencer #(.INSN_WIDTH(4), .TIMEOUT_CYCLES(16), .TO_WIDTH(5)) dut (
    .Clk(Clk), .Rst(Rst), .Run(Run), .StepMode(StepMode), .Step(Step),
    .IpRequest(IpRequest), .IpReady(IpReady), .IpInsn(IpInsn), .dataIsZeroed(dataIsZeroed),
    .ApRequest(ApRequest), .ApDec(ApDec), .ApReady(ApReady),
    .DataRequest(DataRequest), .DataDec(DataDec), .DataReady(DataReady), .DataZero(DataZero),
    .IoOutRequest(IoOutRequest), .IoInRequest(IoInRequest), .IoReady(IoReady),
    .Insn(Insn), .Halted(Halted), .Error(Error)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0, n_err = 0;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  logic dz_prev, dz_rand = 1'b0;
  always @(posedge Clk) dz_prev <= DataZero;

  // IP line: automatic responder or manual drive from the main sequence.
  logic       ip_auto = 1'b0, auto_rdy, man_rdy = 1'b1;
  logic [3:0] auto_insn, man_insn = 4'd0;
  assign IpReady = ip_auto ? auto_rdy : man_rdy;
  assign IpInsn  = ip_auto ? auto_insn : man_insn;

  logic [3:0] prog [0:31];
  int pc = 0, fetch_cnt = 0;
  int pre_lo = 0, pre_hi = 0, low_lo = 1, low_hi = 1;
  int ex_log[$];
  logic data_hang = 1'b0;
  int hang_ack_cyc = -1;
  logic ip_dz;
  int ex_code;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    DataZero = 1'b0;
    forever begin
      @(posedge Clk); #2;
      if (dz_rand) DataZero = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    auto_rdy = 1'b1; auto_insn = 4'd0;
    forever begin
      @(posedge Clk); #1;
      if (ip_auto && IpRequest) begin
        ip_dz = dz_prev;
        fetch_cnt++;
        chk("dz_rise", dataIsZeroed, ip_dz);
        repeat ($urandom_range(pre_lo, pre_hi)) begin @(posedge Clk); #1; chk("dz_hold", dataIsZeroed, ip_dz); end
        auto_rdy = 1'b0;
        repeat ($urandom_range(low_lo, low_hi)) begin @(posedge Clk); #1; chk("dz_hold", dataIsZeroed, ip_dz); end
        auto_rdy = 1'b1; auto_insn = prog[pc]; pc++;
        @(posedge Clk); #1;
        chk("fetch_insn", Insn, prog[pc-1]);
        chk("ip_drop", IpRequest, 0);
      end
    end
  end

  task automatic set_rdy(input int code, input logic v);
    case (code)
      1, 2:    DataReady = v;
      3, 4:    ApReady   = v;
      default: IoReady   = v;
    endcase
  endtask

  initial begin
    ApReady = 1'b1; DataReady = 1'b1; IoReady = 1'b1;
    forever begin
      @(posedge Clk); #1;
      if (ApRequest | DataRequest | IoOutRequest | IoInRequest) begin
        chk("ex_onehot", $countones({ApRequest, DataRequest, IoOutRequest, IoInRequest}), 1);
        ex_code = ApRequest ? (ApDec ? 4 : 3) : DataRequest ? (DataDec ? 2 : 1) : IoOutRequest ? 7 : 8;
        ex_log.push_back(ex_code);
        repeat ($urandom_range(pre_lo, pre_hi)) begin @(posedge Clk); #1; end
        set_rdy(ex_code, 1'b0);
        if (data_hang) begin
          hang_ack_cyc = cyc + 1;
          while (DataRequest) begin @(posedge Clk); #1; end
          set_rdy(ex_code, 1'b1);
        end else begin
          repeat ($urandom_range(low_lo, low_hi)) begin @(posedge Clk); #1; end
          set_rdy(ex_code, 1'b1);
          @(posedge Clk); #1;
          chk("ex_drop", {ApRequest, DataRequest, IoOutRequest, IoInRequest}, 0);
        end
      end
    end
  end

  task automatic do_reset();
    Rst = 1'b1; Run = 1'b0; StepMode = 1'b0; Step = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
  endtask

  task automatic pulse_step();
    Step = 1'b1;
    @(posedge Clk); #1;
    Step = 1'b0;
  endtask

  // Expected effects come straight from the opcode table: every unit opcode
  // before HALT produces one transaction, everything else produces none.
  task automatic run_program(input string tag);
    int exp_q[$];
    int hlt;
    hlt = 0;
    while (hlt < 31 && prog[hlt] != 4'd15) begin
      if (prog[hlt] inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8}) exp_q.push_back(int'(prog[hlt]));
      hlt++;
    end
    pc = 0; fetch_cnt = 0; ex_log.delete();
    Run = 1'b1;
    for (int i = 0; i < 3000 && Halted !== 1'b1; i++) begin @(posedge Clk); #1; end
    chk({tag, "_halted"}, Halted, 1);
    repeat (10) @(posedge Clk);
    #1;
    chk({tag, "_fetches"}, fetch_cnt, hlt + 1);
    chk({tag, "_no_refetch"}, IpRequest, 0);
    chk({tag, "_nlog"}, ex_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < ex_log.size(); i++) chk({tag, "_op"}, ex_log[i], exp_q[i]);
    chk({tag, "_err"}, Error, 0);
    Run = 1'b0;
  endtask

  initial begin
    Rst = 1'b1; Run = 1'b0; StepMode = 1'b0; Step = 1'b0;
    for (int i = 0; i < 32; i++) prog[i] = 4'd15;
    repeat (3) @(posedge Clk);
    #1;
    chk("reset_outs", {IpRequest, dataIsZeroed, ApRequest, ApDec, DataRequest, DataDec,
                       IoOutRequest, IoInRequest, Insn, Halted, Error}, 0);
    Rst = 1'b0;

    // INC, APINC, HALT with fixed unit timing
    ip_auto = 1'b1; pre_lo = 1; pre_hi = 1; low_lo = 1; low_hi = 1;
    prog[0] = 4'd1; prog[1] = 4'd3; prog[2] = 4'd15;
    run_program("prog_basic");

    // Ready high before ACK must not complete the fetch
    do_reset();
    ip_auto = 1'b0; man_rdy = 1'b1; man_insn = 4'd2; ex_log.delete();
    Run = 1'b1;
    for (int i = 0; i < 20 && !IpRequest; i++) begin @(posedge Clk); #1; end
    chk("early_req", IpRequest, 1);
    chk("early_insn", Insn, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk); #1;
      chk("early_insn", Insn, 0);
      chk("early_hold", IpRequest, 1);
    end
    man_rdy = 1'b0;
    @(posedge Clk); #1;
    man_rdy = 1'b1;
    @(posedge Clk); #1;
    chk("late_insn", Insn, 2);
    chk("late_drop", IpRequest, 0);
    Run = 1'b0;
    @(posedge Clk); #1;
    chk("dec_req", DataRequest, 1);
    chk("dec_flag", DataDec, 1);
    repeat (15) @(posedge Clk);
    #1;
    chk("dec_nlog", ex_log.size(), 1);
    if (ex_log.size() > 0) chk("dec_log", ex_log[0], 2);
    chk("stop_idle", IpRequest, 0);

    // Random programs, random unit timing, DataZero toggling mid-fetch
    ip_auto = 1'b1; dz_rand = 1'b1;
    pre_lo = 0; pre_hi = 3; low_lo = 1; low_hi = 3;
    for (int r = 0; r < 5; r++) begin
      int len;
      do_reset();
      len = $urandom_range(3, 12);
      for (int i = 0; i < 32; i++) prog[i] = 4'd15;
      for (int i = 0; i < len - 1; i++) prog[i] = 4'($urandom_range(0, 14));
      run_program("prog_rand");
    end
    dz_rand = 1'b0;

    // Single-step: one fetch per Step pulse
    do_reset();
    prog[0] = 4'd0; prog[1] = 4'd0; prog[2] = 4'd0; prog[3] = 4'd15;
    pc = 0; fetch_cnt = 0;
    StepMode = 1'b1; Run = 1'b1;
    repeat (30) @(posedge Clk);
    #1;
    chk("step_first", fetch_cnt, 1);
    for (int k = 2; k <= 4; k++) begin
      pulse_step();
      repeat (30) @(posedge Clk);
      #1;
      chk("step_fetch", fetch_cnt, k);
    end
    chk("step_halted", Halted, 1);
    pulse_step();
    repeat (30) @(posedge Clk);
    #1;
    chk("step_after_halt", fetch_cnt, 4);

    // DataReady never returns: timeout after 16 cycles in the DONE wait
    do_reset();
    prog[0] = 4'd1; prog[1] = 4'd15;
    pc = 0; pre_lo = 0; pre_hi = 0; data_hang = 1'b1; hang_ack_cyc = -1;
    Run = 1'b1;
    for (int i = 0; i < 100 && hang_ack_cyc < 0; i++) begin @(posedge Clk); #1; end
    chk("to_acked", hang_ack_cyc >= 0, 1);
    if (hang_ack_cyc >= 0) begin
      while (cyc < hang_ack_cyc + 15) begin @(posedge Clk); #1; end
      chk("to_before", Error, 0);
      chk("to_before_req", DataRequest, 1);
      @(posedge Clk); #1;
      chk("to_error", Error, 1);
      chk("to_drop", DataRequest, 0);
    end
    Run = 1'b0;
    repeat (3) @(posedge Clk);
    #1 Run = 1'b1;
    repeat (10) @(posedge Clk);
    #1;
    chk("to_sticky", Error, 1);
    chk("to_no_fetch", IpRequest, 0);
    data_hang = 1'b0;
    do_reset();
    chk("to_cleared", Error, 0);

    // Rst in FETCH_DONE discards the completion
    ip_auto = 1'b0; man_rdy = 1'b1; man_insn = 4'd0;
    Run = 1'b1;
    for (int i = 0; i < 20 && !IpRequest; i++) begin @(posedge Clk); #1; end
    chk("rst_req", IpRequest, 1);
    man_rdy = 1'b0;
    @(posedge Clk); #1;
    Rst = 1'b1; man_rdy = 1'b1; man_insn = 4'd5;
    @(posedge Clk); #1;
    chk("rst_outs", {IpRequest, dataIsZeroed, ApRequest, ApDec, DataRequest, DataDec,
                     IoOutRequest, IoInRequest, Halted, Error}, 0);
    chk("rst_insn", Insn, 0);
    Rst = 1'b0; Run = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_idle", IpRequest, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
